// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared constants for the instruction memory boot loader
package imem_boot_pkg;

  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;

  // Loader FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

endpackage

// File: rtl/imem_boot_loader_timer.sv
// rtl/imem_boot_loader_timer.sv - loadable down-counter timing the CPU reset release
module boot_release_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: reload wins, otherwise count down to zero and hold there
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program into CPU instruction memory, then releases CPU reset
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DEPTH_WORDS   = 256,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [31:0]                      in_data,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             initialize,
  output logic [31:0]                      instruction_initialize_data,
  output logic [ADDR_W-1:0]                instruction_initialize_address,
  output logic                             cpu_rst,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(DEPTH_WORDS+1)-1:0] word_count
);

  localparam int WC_W = $clog2(DEPTH_WORDS + 1);

  logic [2:0]         state_q, state_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               in_ready_q, in_ready_d;
  logic               init_q, init_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic hs;
  logic full;
  logic timer_load;
  logic timer_expired;

  assign hs   = in_valid && in_ready_q && (state_q == ST_LOAD);
  assign full = (wc_q == WC_W'(DEPTH_WORDS));

  boot_release_timer #(
    .CNT_W (4)
  ) u_release_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (4'(RELEASE_DELAY)),
    .en         (state_q == ST_SETTLE),
    .expired    (timer_expired)
  );

  // FSM transitions, word capture, and registered output decode from the next state
  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    data_d     = data_q;
    addr_d     = addr_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          wc_d    = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          if (full) begin
            // Overflowing word is dropped; address and data keep the last good word
            state_d = ST_ERR;
          end else begin
            data_d = in_data;
            addr_d = ADDR_W'(wc_q) * ADDR_W'(WORD_BYTES);
            wc_d   = wc_q + 1'b1;
            if (in_last) begin
              state_d    = ST_SETTLE;
              timer_load = 1'b1;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // initialize stays up one extra cycle on entering SETTLE so the final word lands
    in_ready_d = (state_d == ST_LOAD);
    init_d     = (state_d == ST_LOAD) || ((state_q == ST_LOAD) && (state_d == ST_SETTLE));
    cpu_rst_d  = (state_d != ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    done_d     = (state_d == ST_RUN);
    error_d    = (state_d == ST_ERR);
  end

  // State and output registers; reset holds the CPU in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wc_q       <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      init_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      init_q     <= init_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready                       = in_ready_q;
  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign word_count                     = wc_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int AW    = 32;
  localparam int DEPTH = 12;
  localparam int RD    = 3;
  localparam int WCW   = $clog2(DEPTH + 1);

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_ERR    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [31:0]    in_data = '0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           initialize;
  logic [31:0]    idata;
  logic [AW-1:0]  iaddr;
  logic           cpu_rst;
  logic           busy;
  logic           done;
  logic           error;
  logic [WCW-1:0] word_count;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_W        (AW),
    .DEPTH_WORDS   (DEPTH),
    .RELEASE_DELAY (RD)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .in_valid                       (in_valid),
    .in_data                        (in_data),
    .in_last                        (in_last),
    .in_ready                       (in_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (idata),
    .instruction_initialize_address (iaddr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .error                          (error),
    .word_count                     (word_count)
  );

  int n_vec = 0;
  int n_mis = 0;
  bit checking = 0;

  // Reference model: loader mode plus the image position, release time kept as a cycle stamp
  int          m_mode;
  int          m_wc;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  longint      cyc = 0;
  longint      t_hs = -100;

  logic [31:0] img  [0:15];
  logic [31:0] prog [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_wc   = 0;
    m_data = '0;
    m_addr = '0;
    t_hs   = -100;
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE, M_RUN, M_ERR: if (start) begin m_mode = M_LOAD; m_wc = 0; end
        M_LOAD: begin
          if (in_valid) begin
            if (m_wc == DEPTH) begin
              m_mode = M_ERR;
            end else begin
              m_data = in_data;
              m_addr = m_wc * 4;
              m_wc   = m_wc + 1;
              if (in_last) begin m_mode = M_SETTLE; t_hs = cyc; end
            end
          end
        end
        M_SETTLE: if (cyc == t_hs + RD + 1) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Compare every output against the model each cycle, and mirror imem writes
  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("in_ready",   in_ready,   m_mode == M_LOAD);
      chk("initialize", initialize, (m_mode == M_LOAD) || (m_mode == M_SETTLE && cyc == t_hs));
      chk("data",       idata,      m_data);
      chk("address",    iaddr,      m_addr);
      chk("cpu_rst",    cpu_rst,    m_mode != M_RUN);
      chk("busy",       busy,       (m_mode == M_LOAD) || (m_mode == M_SETTLE));
      chk("done",       done,       m_mode == M_RUN);
      chk("error",      error,      m_mode == M_ERR);
      chk("word_count", word_count, m_wc);
      if (initialize) img[iaddr[5:2]] <= idata;
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
  endtask

  task automatic load_prog(input int n, input bit use_last, input bit bursty);
    int i;
    int g;
    bit v;
    i = 0;
    g = 0;
    while (i < n && g < 400) begin
      v        = bursty ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid = v;
      in_data  = v ? prog[i] : $urandom;
      in_last  = v ? (use_last && i == n - 1) : ($urandom_range(0, 1) == 1);
      if (v && m_mode == M_LOAD) i++;
      cycle();
      g++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("load_guard", i, n);
  endtask

  task automatic wait_release(output int k);
    k = 0;
    while (cpu_rst && k < 40) begin
      cycle();
      k++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_rst"},  cpu_rst,    1);
    chk({tag, "_init"},     initialize, 0);
    chk({tag, "_in_ready"}, in_ready,   0);
    chk({tag, "_addr"},     iaddr,      0);
    chk({tag, "_data"},     idata,      0);
    chk({tag, "_wc"},       word_count, 0);
    chk({tag, "_flags"},    {busy, done, error}, 0);
  endtask

  initial begin
    int k;
    model_reset();
    prog[0]  = 32'h0002_1020; prog[1]  = 32'h0022_1822; prog[2]  = 32'h8C04_0000;
    prog[3]  = 32'hAC05_0004; prog[4]  = 32'h00A6_2024; prog[5]  = 32'h00A6_2825;
    prog[6]  = 32'h00C7_402A; prog[7]  = 32'h2009_0005; prog[8]  = 32'h0800_0000;
    prog[9]  = 32'h0000_0000; prog[10] = 32'h1000_FFFF;
    for (int i = 11; i < 16; i++) prog[i] = $urandom;
    clear_img();

    #1 rst = 1'b1;
    #1 check_reset_values("por");
    cycle();
    cycle();
    rst = 1'b0;
    model_reset();
    checking = 1;

    // in_valid pulses while idle are ignored
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_data  = $urandom;
      in_last  = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // 11-word program back-to-back
    pulse_start();
    load_prog(11, 1, 0);
    wait_release(k);
    chk("hs_to_release", k + 1, RD + 2);
    chk("prog11_wc", word_count, 11);
    chk("prog11_addr", iaddr, 40);
    chk("prog11_data", idata, 32'h1000_FFFF);
    chk("prog11_done", done, 1);
    for (int i = 0; i < 11; i++) chk("prog11_img", img[i], prog[i]);

    // Noise in RUN, then reload with a bursty 3-word source
    for (int i = 0; i < 5; i++) begin
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    clear_img();
    pulse_start();
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_init", initialize, 1);
    chk("reload_done", done, 0);
    load_prog(3, 1, 1);
    wait_release(k);
    chk("burst_release", k, RD + 1);
    chk("burst_wc", word_count, 3);
    for (int i = 0; i < 3; i++) chk("burst_img", img[i], prog[i]);
    chk("burst_img_untouched", img[3], 0);

    // Overflow: DEPTH+1 words without in_last
    pulse_start();
    load_prog(DEPTH + 1, 0, 0);
    chk("ovf_error", error, 1);
    chk("ovf_cpu_rst", cpu_rst, 1);
    chk("ovf_init", initialize, 0);
    chk("ovf_addr", iaddr, (DEPTH - 1) * 4);
    chk("ovf_wc", word_count, DEPTH);
    pulse_start();
    chk("ovf_restart_error", error, 0);
    chk("ovf_restart_wc", word_count, 0);

    // Exactly DEPTH words with in_last fits
    load_prog(DEPTH, 1, 0);
    wait_release(k);
    chk("full_release", k, RD + 1);
    chk("full_wc", word_count, DEPTH);

    // Async reset mid-load after 3 words
    pulse_start();
    load_prog(3, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset_values("async");
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // Single-word program with idle in_valid noise
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      cycle();
      in_valid = 1'b0;
      cycle();
    end
    clear_img();
    prog[0] = $urandom;
    pulse_start();
    load_prog(1, 1, 0);
    wait_release(k);
    chk("single_release", k, RD + 1);
    chk("single_wc", word_count, 1);
    chk("single_addr", iaddr, 0);
    chk("single_img", img[0], prog[0]);

    // Free-running random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      start    = ($urandom_range(0, 39) == 0);
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      in_last  = ($urandom_range(0, 7) == 0);
      cycle();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program load into the single-cycle CPU's instruction memory through the cpu init port (initialize / instruction_initialize_data / instruction_initialize_address), then releases the CPU from reset.
- Sits between a word-streaming source (host/UART bridge/ROM reader) and the cpu top; replaces bench-driven init sequencing.
- Owns the CPU reset while loading; supports reload on request and flags overflow.

Parameters:
- ADDR_W, 32, width of instruction_initialize_address (byte address).
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- RELEASE_DELAY, 2, cycles cpu_rst stays high after initialize drops (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse: begin (re)load; sampled in IDLE, RUN, ERR only.
- in_valid  input  1  source word valid.
- in_data  input  32  instruction word.
- in_last  input  1  qualifies final word of program (with in_valid).
- in_ready  output  1  loader accepts word this cycle.
- initialize  output  1  to cpu.initialize; imem write enable.
- instruction_initialize_data  output  32  to cpu.
- instruction_initialize_address  output  ADDR_W  to cpu; byte address, word aligned.
- cpu_rst  output  1  to cpu.rst.
- busy  output  1  high in LOAD/SETTLE.
- done  output  1  high in RUN.
- error  output  1  high in ERR.
- word_count  output  $clog2(DEPTH_WORDS+1)  words accepted in current load.

Behaviour:
- All outputs registered. Reset (async): state=IDLE, cpu_rst=1, initialize=0, in_ready=0, data=0, address=0, word_count=0, busy=done=error=0.
- States: IDLE, LOAD, SETTLE, RUN, ERR.
- IDLE: cpu_rst=1. start -> LOAD next cycle; word_count cleared, initialize=1.
- LOAD: initialize=1, in_ready=1, cpu_rst=1. Handshake = in_valid & in_ready. On handshake: data<=in_data, address<=word_count*4 (zero-extended to ADDR_W), word_count<=word_count+1; visible next cycle. Between handshakes outputs hold (imem rewrites same word; harmless). start ignored.
- Overflow: handshake when word_count==DEPTH_WORDS -> ERR; word not presented, address not advanced.
- in_last on accepted handshake (not overflow) -> SETTLE; in_ready drops next cycle.
- SETTLE: first cycle initialize=1 (final word written), then initialize=0, cpu_rst=1 for RELEASE_DELAY cycles, then RUN. Last handshake to cpu_rst falling = RELEASE_DELAY+2 cycles.
- RUN: cpu_rst=0, initialize=0, done=1, in_ready=0. start -> LOAD: cpu_rst=1 and initialize=1 same next edge (CPU never runs during writes).
- ERR: cpu_rst=1, initialize=0, error=1, in_ready=0. start -> LOAD (clears error).
- Async rst mid-load: immediate return to IDLE values; partial image discarded, CPU held in reset.
- in_valid outside LOAD: ignored, no state change.
- Minimum program 1 word (in_last on first word). Address wraps never (bounded by overflow check).

Decomposition:
- Shared package imem_boot_pkg: state enum (IDLE, LOAD, SETTLE, RUN, ERR), WORD_BYTES=4, INSTR_W=32.
- One sub-module natural: boot_release_timer (loadable down-counter for RELEASE_DELAY, outputs expired). Rest is one FSM plus counter.

Test Plan:
- Load 11 words (ADD 0x00021020 @0 ... BEQ @40) back-to-back, in_last on 11th -> addresses 0,4,...,40 each with matching data one cycle after handshake; word_count=11; cpu_rst falls RELEASE_DELAY+2 cycles after last handshake; done=1.
- Bursty source (in_valid toggled 1/0) loading 3 words -> addresses 0,4,8 only, held values unchanged during gaps, no extra word_count increments.
- DEPTH_WORDS=4, stream 5 words without in_last -> words 0..3 at 0..12, 5th causes error=1, cpu_rst=1, initialize=0, address stays 12; start -> LOAD, error=0, word_count=0.
- In RUN pulse start, reload 2 words -> cpu_rst=1 and initialize=1 on same edge, addresses restart at 0, done=0 until re-release.
- Assert rst asynchronously mid-LOAD after 3 words -> outputs at reset values immediately (no clock edge), state IDLE, cpu_rst=1.
- Single-word program (in_last on first word) plus in_valid pulses while IDLE -> IDLE pulses ignored; word at address 0, word_count=1, proper release.
